// File: rtl/demux_pkg.sv
// Shared types and constants for the 1:8 serial deserializer.
// The index width and last position follow the 8:1 mux on the sending side.
package demux_pkg;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    return cur + 1'b1;
  endfunction

endpackage

// File: rtl/demux1to8.sv
// Combinational 1:8 demultiplexer producing one-hot write enables.
// All outputs stay low when en is low.
module demux1to8
  import demux_pkg::*;
(
  input  logic             en,
  input  logic [IDX_W-1:0] sel,
  output logic [WIDTH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel collector: steers LSB-first bits into a byte, then
// holds the byte on a valid/ready output with backpressure on the serial side.
module demux_deser8
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  state_t           state;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] wr_en;
  logic             accept;
  logic             handshake;

  // While a word is held, a new bit may only enter on the edge that hands it off.
  assign din_ready  = (state == FULL) ? (dout_ready & ~flush) : ~flush;
  assign accept     = din_valid & din_ready;
  assign handshake  = (state == FULL) & dout_ready;
  assign dout       = word;
  assign dout_valid = (state == FULL);

  demux1to8 u_demux (
    .en     (accept),
    .sel    (idx),
    .onehot (wr_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      word  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (flush) begin
            idx  <= '0;
            word <= '0;
          end else if (accept) begin
            word <= (word & ~wr_en) | (wr_en & {WIDTH{din}});
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= FULL;
            end else begin
              idx <= next_idx(idx);
            end
          end
        end
        FULL: begin
          // idx is 0 here, so a same-edge bit lands in word[0] with no bubble.
          if (handshake) begin
            state <= FILL;
            if (accept) begin
              word <= wr_en & {WIDTH{din}};
              idx  <= next_idx(idx);
            end else begin
              word <= '0;
              idx  <= '0;
            end
          end
        end
        default: begin
          state <= FILL;
          idx   <= '0;
          word  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_deser8.sv
// Directed bench for demux_deser8: table of per-cycle vectors plus
// hand-written sequences for backpressure and mid-operation reset.
module tb_demux_deser8;

  typedef struct {
    string      name;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       flush;
    logic       dout_ready;
    logic       exp_rdy;
    logic [2:0] exp_idx;
    logic [7:0] exp_dout;
    logic       exp_dv;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       flush;
  logic [2:0] idx;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  demux_deser8 #(.WIDTH(8), .IDX_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .flush      (flush),
    .idx        (idx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input logic r, input logic d, input logic dv,
                              input logic f, input logic dr, input logic er,
                              input logic [2:0] ei, input logic [7:0] ed, input logic edv);
    vec_t v;
    v.name = n; v.rst = r; v.din = d; v.din_valid = dv; v.flush = f; v.dout_ready = dr;
    v.exp_rdy = er; v.exp_idx = ei; v.exp_dout = ed; v.exp_dv = edv;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive away from the edge, check din_ready before the edge, registers after it.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst        = v.rst;
    din        = v.din;
    din_valid  = v.din_valid;
    flush      = v.flush;
    dout_ready = v.dout_ready;
    #1;
    checkOutput({v.name, " din_ready"}, {7'b0, din_ready}, {7'b0, v.exp_rdy});
    @(posedge clk);
    #1;
    checkOutput({v.name, " idx"}, {5'b0, idx}, {5'b0, v.exp_idx});
    checkOutput({v.name, " dout"}, dout, v.exp_dout);
    checkOutput({v.name, " dout_valid"}, {7'b0, dout_valid}, {7'b0, v.exp_dv});
  endtask

  // One byte LSB-first from an empty word; expected word is the byte masked to bits seen so far.
  task automatic addByte(input string n, input logic [7:0] val, input logic dr);
    logic [8:0] m;
    for (int k = 0; k < 8; k++) begin
      m = (9'd1 << (k + 1)) - 9'd1;
      vecs.push_back(mk(n, 1'b0, val[k], 1'b1, 1'b0, dr, 1'b1, 3'(k + 1), val & m[7:0], k == 7));
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; flush = 1'b0; dout_ready = 1'b0;

    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("idle", 0, 0, 0, 0, 0, 1, 3'd0, 8'h00, 0));
    addByte("byteCA", 8'hCA, 1'b0);
    vecs.push_back(mk("takeCA", 0, 0, 0, 0, 1, 1, 3'd0, 8'h00, 0));
    addByte("b2bFF", 8'hFF, 1'b1);
    addByte("b2b00", 8'h00, 1'b1);
    vecs.push_back(mk("take00", 0, 0, 0, 0, 1, 1, 3'd0, 8'h00, 0));
    vecs.push_back(mk("pre1", 0, 1, 1, 0, 0, 1, 3'd1, 8'h01, 0));
    vecs.push_back(mk("pre2", 0, 1, 1, 0, 0, 1, 3'd2, 8'h03, 0));
    vecs.push_back(mk("pre3", 0, 1, 1, 0, 0, 1, 3'd3, 8'h07, 0));
    vecs.push_back(mk("flushFill", 0, 1, 1, 1, 0, 0, 3'd0, 8'h00, 0));
    addByte("byte81", 8'h81, 1'b0);
    vecs.push_back(mk("flushFull", 0, 1, 1, 1, 0, 0, 3'd0, 8'h81, 1));
    vecs.push_back(mk("flushTake", 0, 1, 1, 1, 1, 0, 3'd0, 8'h00, 0));

    repeat (2) @(posedge clk);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Backpressure on a held 0x5A, then handoff with a new bit on the same edge.
    applyStimulus(mk("bp0", 0, 0, 1, 0, 0, 1, 3'd1, 8'h00, 0));
    applyStimulus(mk("bp1", 0, 1, 1, 0, 0, 1, 3'd2, 8'h02, 0));
    applyStimulus(mk("bp2", 0, 0, 1, 0, 0, 1, 3'd3, 8'h02, 0));
    applyStimulus(mk("bp3", 0, 1, 1, 0, 0, 1, 3'd4, 8'h0A, 0));
    applyStimulus(mk("bp4", 0, 1, 1, 0, 0, 1, 3'd5, 8'h1A, 0));
    applyStimulus(mk("bp5", 0, 0, 1, 0, 0, 1, 3'd6, 8'h1A, 0));
    applyStimulus(mk("bp6", 0, 1, 1, 0, 0, 1, 3'd7, 8'h5A, 0));
    applyStimulus(mk("bp7", 0, 0, 1, 0, 0, 1, 3'd0, 8'h5A, 1));
    for (int i = 0; i < 4; i++)
      applyStimulus(mk("bpHold", 0, 1, 1, 0, 0, 0, 3'd0, 8'h5A, 1));
    applyStimulus(mk("bpHandoff", 0, 1, 1, 0, 1, 1, 3'd1, 8'h01, 0));
    for (int k = 1; k < 8; k++)
      applyStimulus(mk("bpRest", 0, 0, 1, 0, 0, 1, 3'(k + 1), 8'h01, k == 7));
    applyStimulus(mk("bpTake", 0, 0, 0, 0, 1, 1, 3'd0, 8'h00, 0));

    // Reset mid-word, then a clean 0x3C, then reset while a word is held.
    applyStimulus(mk("rw0", 0, 1, 1, 0, 0, 1, 3'd1, 8'h01, 0));
    applyStimulus(mk("rw1", 0, 0, 1, 0, 0, 1, 3'd2, 8'h01, 0));
    applyStimulus(mk("rw2", 0, 1, 1, 0, 0, 1, 3'd3, 8'h05, 0));
    applyStimulus(mk("rw3", 0, 1, 1, 0, 0, 1, 3'd4, 8'h0D, 0));
    applyStimulus(mk("rw4", 0, 0, 1, 0, 0, 1, 3'd5, 8'h0D, 0));
    applyStimulus(mk("rstFill", 1, 1, 1, 0, 0, 1, 3'd0, 8'h00, 0));
    applyStimulus(mk("c0", 0, 0, 1, 0, 0, 1, 3'd1, 8'h00, 0));
    applyStimulus(mk("c1", 0, 0, 1, 0, 0, 1, 3'd2, 8'h00, 0));
    applyStimulus(mk("c2", 0, 1, 1, 0, 0, 1, 3'd3, 8'h04, 0));
    applyStimulus(mk("c3", 0, 1, 1, 0, 0, 1, 3'd4, 8'h0C, 0));
    applyStimulus(mk("c4", 0, 1, 1, 0, 0, 1, 3'd5, 8'h1C, 0));
    applyStimulus(mk("c5", 0, 1, 1, 0, 0, 1, 3'd6, 8'h3C, 0));
    applyStimulus(mk("c6", 0, 0, 1, 0, 0, 1, 3'd7, 8'h3C, 0));
    applyStimulus(mk("c7", 0, 0, 1, 0, 0, 1, 3'd0, 8'h3C, 1));
    applyStimulus(mk("rstFull", 1, 0, 0, 0, 0, 0, 3'd0, 8'h00, 0));
    applyStimulus(mk("postRst", 0, 0, 0, 0, 0, 1, 3'd0, 8'h00, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
